// File: rtl/gate_exerciser.sv
// Sequences a 2-input gate through vectors 00,01,10,11, samples its output after a settle
// period and compares against an expected truth table; reports pass, mismatch count and failing vectors.
module gate_exerciser #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] expected_tt,
   output logic       a_out,
   output logic       b_out,
   input  logic       c_in,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] mismatch_cnt,
   output logic [3:0] fail_vec
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

   state_t     state_q;
   logic [1:0] idx_q;
   logic [3:0] cnt_q;
   logic [3:0] tt_q;
   logic       a_q, b_q, busy_q, done_q, pass_q;
   logic [2:0] mcnt_q;
   logic [3:0] fv_q;

   logic       mis_d;
   logic [2:0] mcnt_d;
   logic [1:0] idx_d;

   // c_in is combinational from a_out/b_out, which are stable for the whole vector
   assign mis_d  = (c_in != tt_q[idx_q]);
   assign mcnt_d = mcnt_q + {2'b00, mis_d};
   assign idx_d  = idx_q + 2'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         tt_q    <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         mcnt_q  <= '0;
         fv_q    <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  tt_q    <= expected_tt;
                  idx_q   <= '0;
                  cnt_q   <= '0;
                  mcnt_q  <= '0;
                  fv_q    <= '0;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  a_q     <= 1'b0;
                  b_q     <= 1'b0;
                  state_q <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt_q == CNT_LAST) state_q <= SAMPLE;
               else                   cnt_q   <= cnt_q + 4'd1;
            end
            SAMPLE: begin
               if (mis_d) fv_q[idx_q] <= 1'b1;
               mcnt_q <= mcnt_d;
               if (idx_q == 2'd3) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (mcnt_d == 3'd0);
                  a_q     <= 1'b0;
                  b_q     <= 1'b0;
                  state_q <= DONE;
               end else begin
                  idx_q   <= idx_d;
                  a_q     <= idx_d[1];
                  b_q     <= idx_d[0];
                  cnt_q   <= '0;
                  state_q <= SETTLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign a_out        = a_q;
   assign b_out        = b_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign mismatch_cnt = mcnt_q;
   assign fail_vec     = fv_q;

endmodule
